// File: rtl/clz_seq_unit.sv
// Iterative CLZ/CLO unit that scans one nibble per cycle, with a start/done handshake.
// Build option CLZ_EARLY_EXIT_EN: stop at the first nonzero nibble; otherwise always scan 8 nibbles.
module clz_seq_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_t;

   state_t      state;
   logic [31:0] shreg;
   logic [5:0]  count;
   logic [2:0]  idx;
   logic [5:0]  res_q;
   logic [3:0]  nib;
   logic [5:0]  nib_lz;
   logic [5:0]  count_nxt;
`ifndef CLZ_EARLY_EXIT_EN
   logic        found;
`endif

   assign nib    = shreg[31:28];
   assign busy   = (state == ST_SCAN);
   assign done   = (state == ST_DONE);
   assign result = {26'b0, res_q};

   always_comb begin
      nib_lz = 6'd0;
      if (nib[3])
         nib_lz = 6'd0;
      else if (nib[2])
         nib_lz = 6'd1;
      else if (nib[1])
         nib_lz = 6'd2;
      else
         nib_lz = 6'd3;
   end

   // The fixed-latency build keeps scanning after a hit but freezes the count.
   always_comb begin
      count_nxt = count;
`ifdef CLZ_EARLY_EXIT_EN
      count_nxt = (nib == 4'd0) ? count + 6'd4 : count + nib_lz;
`else
      if (!found)
         count_nxt = (nib == 4'd0) ? count + 6'd4 : count + nib_lz;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         shreg <= 32'd0;
         count <= 6'd0;
         idx   <= 3'd0;
         res_q <= 6'd0;
`ifndef CLZ_EARLY_EXIT_EN
         found <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  shreg <= op ? ~data_in : data_in;
                  count <= 6'd0;
                  idx   <= 3'd0;
`ifndef CLZ_EARLY_EXIT_EN
                  found <= 1'b0;
`endif
                  state <= ST_SCAN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               count <= count_nxt;
`ifdef CLZ_EARLY_EXIT_EN
               if (nib != 4'd0 || idx == 3'd7) begin
                  res_q <= count_nxt;
                  state <= ST_DONE;
               end else begin
                  shreg <= shreg << 4;
                  idx   <= idx + 3'd1;
               end
`else
               if (nib != 4'd0)
                  found <= 1'b1;
               shreg <= shreg << 4;
               idx   <= idx + 3'd1;
               if (idx == 3'd7) begin
                  res_q <= count_nxt;
                  state <= ST_DONE;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clz_seq_unit.sv
// Directed bench for clz_seq_unit: reset, CLZ sweep, CLO, handshake, back-to-back, random operands.
// Expected latencies follow CLZ_EARLY_EXIT_EN when it is defined for the bench build.
module tb_clz_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] data_in = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clz_seq_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   function automatic int expectedLat(input int r);
`ifdef CLZ_EARLY_EXIT_EN
      return (r == 32) ? 9 : r / 4 + 2;
`else
      return 9;
`endif
   endfunction

   // Bit-serial reference count, independent of the nibble scan.
   function automatic logic [31:0] refCount(input logic o, input logic [31:0] d);
      logic [31:0] x;
      logic        hit;
      int          n;
      x   = o ? ~d : d;
      hit = 1'b0;
      n   = 0;
      for (int i = 31; i >= 0; i--) begin
         if (!hit) begin
            if (x[i])
               hit = 1'b1;
            else
               n++;
         end
      end
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   // Called #1 after the accepting edge; returns the cycle in which done was seen (or the budget).
   task automatic waitDone(output int cycles);
      cycles = 1;
      while (!done && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic applyStimulus(input logic o, input logic [31:0] d, input logic [31:0] expRes, input string tag);
      int cycles;
      @(posedge clk);
      #1;
      start   = 1'b1;
      op      = o;
      data_in = d;
      @(posedge clk);
      #1;
      start   = 1'b0;
      op      = ~o;
      data_in = $urandom;
      waitDone(cycles);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, "_res"}, result, expRes);
      checkOutput({tag, "_lat"}, cycles, expectedLat(int'(expRes)));
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold"}, result, expRes);
   endtask

   initial begin
      int          cycles;
      logic        busyOk;
      logic        sawDone;
      logic [31:0] d;
      logic        o;
      logic [31:0] ones;

      #3;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      rst_n = 1'b1;

      ones = 32'hFFFF_FFFF;
      for (int i = 0; i <= 32; i++) begin
         d = (i == 32) ? 32'd0 : (ones >> i);
         applyStimulus(1'b0, d, i, $sformatf("clz%0d", i));
      end

      applyStimulus(1'b1, 32'hF000_0000, 32'd4, "clo_f0");
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd32, "clo_ff");
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd0, "clo_7f");

      // start held high through the whole scan; only the DONE cycle may accept again
      @(posedge clk);
      #1;
      start   = 1'b1;
      op      = 1'b0;
      data_in = 32'd0;
      @(posedge clk);
      #1;
      data_in = 32'h1234_5678;
      busyOk  = 1'b1;
      cycles  = 1;
      while (!done && cycles < 20) begin
         if (!busy)
            busyOk = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("hs_busy", {31'd0, busyOk}, 32'd1);
      checkOutput("hs_done", {31'd0, done}, 32'd1);
      checkOutput("hs_res", result, 32'd32);
      checkOutput("hs_lat", cycles, 32'd9);
      data_in = 32'h0010_0000;
      @(posedge clk);
      #1;
      checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
      start   = 1'b0;
      data_in = 32'hFFFF_FFFF;
      waitDone(cycles);
      checkOutput("b2b_done", {31'd0, done}, 32'd1);
      checkOutput("b2b_res", result, 32'd11);
      checkOutput("b2b_lat", cycles, expectedLat(11));

      for (int k = 0; k < 100; k++) begin
         d = $urandom >> $urandom_range(0, 31);
         o = 1'($urandom_range(0, 1));
         applyStimulus(o, d, refCount(o, d), $sformatf("rnd%0d", k));
      end

      // reset in the middle of a long scan
      applyStimulus(1'b0, 32'h0000_1000, 32'd19, "pre_rst");
      @(posedge clk);
      #1;
      start   = 1'b1;
      op      = 1'b0;
      data_in = 32'h0000_0001;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_done", {31'd0, done}, 32'd0);
      checkOutput("midrst_result", result, 32'd0);
      #2;
      rst_n   = 1'b1;
      sawDone = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (done)
            sawDone = 1'b1;
      end
      checkOutput("postrst_nodone", {31'd0, sawDone}, 32'd0);
      checkOutput("postrst_busy", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
